// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: job scheduler for the binary 3x3 XNOR convolution accelerator.
// The host queues jobs in a small FIFO. Jobs launch one at a time with a one-cycle acc_run_o
// pulse, and the sequencer follows acc_busy_i until the job completes. Each completion
// produces a record on a valid/ready handshake with the job id and the elapsed cycle count.
//
// Optional feature macro: TIMEOUT_EN. When it is defined, watchdogs abort jobs stuck in
// WAIT_BUSY or RUN. When it is undefined, done_timeout_o is tied to 0.
//
// Ports:
//   clk_i, reset_i        clock; synchronous active-high reset
//   job_valid_i/ready_o   host job push handshake
//   job_*_i               job descriptor (input/output/weight address, id)
//   acc_run_o             one-cycle launch pulse
//   acc_busy_i            accelerator busy
//   acc_*_o               descriptor of the current job
//   done_valid_o/ready_i  completion handshake
//   done_id_o             id of the completed job
//   done_cycles_o         cycles spent in WAIT_BUSY plus RUN (saturating)
//   done_timeout_o        job aborted by the watchdog
//   seq_idle_o            IDLE state with an empty queue
//   fifo_count_o          queue occupancy
module conv_job_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ID_W          = 4,
  parameter int unsigned CYC_W         = 16,
  parameter int unsigned START_TIMEOUT = 8,
  parameter int unsigned RUN_TIMEOUT   = 4096
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        job_valid_i,
  output logic                        job_ready_o,
  input  logic [11:0]                 job_in_base_i,
  input  logic [11:0]                 job_out_base_i,
  input  logic [11:0]                 job_wgt_addr_i,
  input  logic [ID_W-1:0]             job_id_i,
  output logic                        acc_run_o,
  input  logic                        acc_busy_i,
  output logic [11:0]                 acc_in_base_o,
  output logic [11:0]                 acc_out_base_o,
  output logic [11:0]                 acc_wgt_addr_o,
  output logic                        done_valid_o,
  input  logic                        done_ready_i,
  output logic [ID_W-1:0]             done_id_o,
  output logic [CYC_W-1:0]            done_cycles_o,
  output logic                        done_timeout_o,
  output logic                        seq_idle_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 36 + ID_W;

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitBusy, StRun, StDone} state_e;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (START_TIMEOUT == 0 || RUN_TIMEOUT == 0) begin : g_bad_timeout
    $error("START_TIMEOUT and RUN_TIMEOUT must be non-zero");
  end

  // Job queue
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [EntW-1:0] head;

  assign job_ready_o = (count_q < CntW'(FIFO_DEPTH));
  assign push        = job_valid_i & job_ready_o;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {job_id_i, job_wgt_addr_i, job_out_base_i, job_in_base_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Sequencer
  state_e           state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [11:0]      in_base_q, out_base_q, wgt_q;
  logic [ID_W-1:0]  id_q;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CYC_W'(1);

`ifdef TIMEOUT_EN
  logic timeout_set;
  logic timeout_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
`ifdef TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        cnt_d = cnt_inc;
        if (acc_busy_i) begin
          state_d = StRun;
`ifdef TIMEOUT_EN
        end else if (cnt_inc == CYC_W'(START_TIMEOUT)) begin
          state_d     = StDone;
          timeout_set = 1'b1;
`endif
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (!acc_busy_i) begin
          state_d = StDone;
`ifdef TIMEOUT_EN
        end else if (cnt_inc == CYC_W'(RUN_TIMEOUT)) begin
          state_d     = StDone;
          timeout_set = 1'b1;
`endif
        end
      end
      StDone: begin
        if (done_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      wgt_q      <= '0;
      id_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Descriptor registers only move on a pop, so they stay stable through DONE.
      if (pop) begin
        {id_q, wgt_q, out_base_q, in_base_q} <= head;
      end
    end
  end

`ifdef TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timeout_q <= 1'b0;
    end else if (state_q == StLaunch) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end
  end
  assign done_timeout_o = timeout_q;
`else
  assign done_timeout_o = 1'b0;
`endif

  assign acc_run_o      = (state_q == StLaunch);
  assign done_valid_o   = (state_q == StDone);
  assign seq_idle_o     = (state_q == StIdle) && (count_q == '0);
  assign acc_in_base_o  = in_base_q;
  assign acc_out_base_o = out_base_q;
  assign acc_wgt_addr_o = wgt_q;
  assign done_id_o      = id_q;
  assign done_cycles_o  = cnt_q;
  assign fifo_count_o   = count_q;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed self-checking bench for conv_job_sequencer with a simple accelerator busy model.
module tb_conv_job_sequencer;
  localparam int unsigned ID_W  = 4;
  localparam int unsigned CYC_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [11:0]      job_in_base = '0, job_out_base = '0, job_wgt_addr = '0;
  logic [ID_W-1:0]  job_id = '0;
  logic             acc_run;
  logic             acc_busy = 1'b0;
  logic [11:0]      acc_in_base, acc_out_base, acc_wgt_addr;
  logic             done_valid;
  logic             done_ready = 1'b0;
  logic [ID_W-1:0]  done_id;
  logic [CYC_W-1:0] done_cycles;
  logic             done_timeout;
  logic             seq_idle;
  logic [2:0]       fifo_count;

  int total = 0;
  int bad   = 0;

  // Accelerator model: busy rises the cycle after acc_run and stays up busy_hold cycles.
  int   busy_hold    = 0;
  logic hold_forever = 1'b0;
  logic kick         = 1'b0;
  int   bcnt         = 0;
  int   done_log[$];

  conv_job_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .job_valid_i   (job_valid),
    .job_ready_o   (job_ready),
    .job_in_base_i (job_in_base),
    .job_out_base_i(job_out_base),
    .job_wgt_addr_i(job_wgt_addr),
    .job_id_i      (job_id),
    .acc_run_o     (acc_run),
    .acc_busy_i    (acc_busy),
    .acc_in_base_o (acc_in_base),
    .acc_out_base_o(acc_out_base),
    .acc_wgt_addr_o(acc_wgt_addr),
    .done_valid_o  (done_valid),
    .done_ready_i  (done_ready),
    .done_id_o     (done_id),
    .done_cycles_o (done_cycles),
    .done_timeout_o(done_timeout),
    .seq_idle_o    (seq_idle),
    .fifo_count_o  (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (kick) begin
      acc_busy <= 1'b1;
      bcnt     <= 0;
    end else if (acc_run && busy_hold > 0) begin
      acc_busy <= 1'b1;
      bcnt     <= busy_hold - 1;
    end else if (acc_busy && !hold_forever) begin
      if (bcnt == 0) acc_busy <= 1'b0;
      else           bcnt     <= bcnt - 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && done_valid && done_ready) done_log.push_back(int'(done_id));
  end

  function automatic logic [11:0] exp_in(input int id);
    return 12'(id * 16);
  endfunction
  function automatic logic [11:0] exp_out(input int id);
    return 12'(2048 + id);
  endfunction
  function automatic logic [11:0] exp_wgt(input int id);
    return 12'(id * 3);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int id);
    job_id       = ID_W'(id);
    job_in_base  = exp_in(id);
    job_out_base = exp_out(id);
    job_wgt_addr = exp_wgt(id);
  endtask

  task automatic push_job(input int id);
    set_job(id);
    job_valid = 1'b1;
    for (int i = 0; i < 50 && !job_ready; i++) cyc();
    cyc();
    job_valid = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (acc_run) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_valid) begin
        ok = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  task automatic handshake();
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL reset_job_ready got=%0b want=1", job_ready); end
    total++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL reset_seq_idle got=%0b want=1", seq_idle); end
    total++; if (acc_run !== 1'b0) begin bad++; $display("FAIL reset_acc_run got=%0b want=0", acc_run); end
    total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL reset_done_valid got=%0b want=0", done_valid); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_fifo_count got=%0d want=0", fifo_count); end
    total++; if (done_cycles !== 16'd0) begin bad++; $display("FAIL reset_done_cycles got=%0d want=0", done_cycles); end
    total++; if (acc_in_base !== 12'h0) begin bad++; $display("FAIL reset_acc_in_base got=%0h want=0", acc_in_base); end
    total++; if (done_timeout !== 1'b0) begin bad++; $display("FAIL reset_done_timeout got=%0b want=0", done_timeout); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    bit ok;
    busy_hold = 20;
    job_id = 4'd3; job_in_base = 12'h000; job_out_base = 12'h100; job_wgt_addr = 12'h001;
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    total++; if (acc_run !== 1'b0) begin bad++; $display("FAIL single_run_early got=%0b want=0", acc_run); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", fifo_count); end
    cyc();
    total++; if (acc_run !== 1'b1) begin bad++; $display("FAIL single_run_latency got=%0b want=1", acc_run); end
    total++; if (acc_in_base !== 12'h000) begin bad++; $display("FAIL single_in_base got=%0h want=000", acc_in_base); end
    total++; if (acc_out_base !== 12'h100) begin bad++; $display("FAIL single_out_base got=%0h want=100", acc_out_base); end
    total++; if (acc_wgt_addr !== 12'h001) begin bad++; $display("FAIL single_wgt got=%0h want=001", acc_wgt_addr); end
    cyc();
    total++; if (acc_run !== 1'b0) begin bad++; $display("FAIL single_run_width got=%0b want=0", acc_run); end
    wait_done(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_done_wait got=%0b want=1", ok); end
    total++; if (done_id !== 4'd3) begin bad++; $display("FAIL single_done_id got=%0d want=3", done_id); end
    total++; if (done_cycles !== 16'd21) begin bad++; $display("FAIL single_done_cycles got=%0d want=21", done_cycles); end
    total++; if (done_timeout !== 1'b0) begin bad++; $display("FAIL single_done_timeout got=%0b want=0", done_timeout); end
    handshake();
    total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL single_done_clear got=%0b want=0", done_valid); end
    total++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%0b want=1", seq_idle); end
  endtask

  task automatic test_backpressure();
    bit ok;
    busy_hold = 3;
    push_job(5);
    push_job(6);
    wait_done(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_done_wait got=%0b want=1", ok); end
    for (int i = 0; i < 10; i++) begin
      total++; if (done_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b want=1", i, done_valid); end
      total++; if (done_id !== 4'd5) begin bad++; $display("FAIL bp_id[%0d] got=%0d want=5", i, done_id); end
      total++; if (done_cycles !== 16'd4) begin bad++; $display("FAIL bp_cycles[%0d] got=%0d want=4", i, done_cycles); end
      total++; if (done_timeout !== 1'b0) begin bad++; $display("FAIL bp_timeout[%0d] got=%0b want=0", i, done_timeout); end
      total++; if (acc_run !== 1'b0) begin bad++; $display("FAIL bp_no_run[%0d] got=%0b want=0", i, acc_run); end
      cyc();
    end
    handshake();
    total++; if (acc_run !== 1'b0) begin bad++; $display("FAIL bp_idle_gap got=%0b want=0", acc_run); end
    cyc();
    total++; if (acc_run !== 1'b1) begin bad++; $display("FAIL bp_next_run got=%0b want=1", acc_run); end
    total++; if (acc_in_base !== exp_in(6)) begin bad++; $display("FAIL bp_next_in got=%0h want=%0h", acc_in_base, exp_in(6)); end
    wait_done(ok);
    total++; if (done_id !== 4'd6) begin bad++; $display("FAIL bp_second_id got=%0d want=6", done_id); end
    handshake();
  endtask

  task automatic test_push_pop();
    bit ok;
    busy_hold = 2;
    push_job(7);
    wait_done(ok);
    push_job(8);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL pp_count_pre got=%0d want=1", fifo_count); end
    handshake();
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL pp_count_idle got=%0d want=1", fifo_count); end
    set_job(9);
    job_valid = 1'b1;
    cyc();
    job_valid = 1'b0;
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL pp_count_same got=%0d want=1", fifo_count); end
    total++; if (acc_run !== 1'b1) begin bad++; $display("FAIL pp_launch got=%0b want=1", acc_run); end
    total++; if (acc_wgt_addr !== exp_wgt(8)) begin bad++; $display("FAIL pp_wgt got=%0h want=%0h", acc_wgt_addr, exp_wgt(8)); end
    wait_done(ok);
    total++; if (done_id !== 4'd8) begin bad++; $display("FAIL pp_id8 got=%0d want=8", done_id); end
    handshake();
    wait_done(ok);
    total++; if (done_id !== 4'd9) begin bad++; $display("FAIL pp_id9 got=%0d want=9", done_id); end
    handshake();
  endtask

  task automatic test_queue_full();
    bit ok;
    bit got;
    int base;
    base = done_log.size();
    hold_forever = 1'b1;
    busy_hold = 2;
    done_ready = 1'b1;
    push_job(1);
    wait_run(ok);
    cyc(); cyc();
    for (int id = 2; id <= 5; id++) push_job(id);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", fifo_count); end
    total++; if (job_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", job_ready); end
    set_job(6);
    job_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_hold_count[%0d] got=%0d want=4", i, fifo_count); end
    end
    hold_forever = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (job_ready) begin
        got = 1'b1;
        total++; if (acc_run !== 1'b1) begin bad++; $display("FAIL full_accept_run got=%0b want=1", acc_run); end
        total++; if (acc_in_base !== exp_in(2)) begin bad++; $display("FAIL full_accept_job got=%0h want=%0h", acc_in_base, exp_in(2)); end
      end
      cyc();
    end
    job_valid = 1'b0;
    total++; if (got !== 1'b1) begin bad++; $display("FAIL full_accept got=%0b want=1", got); end
    for (int i = 0; i < 300 && done_log.size() < base + 6; i++) cyc();
    done_ready = 1'b0;
    total++; if (done_log.size() !== base + 6) begin bad++; $display("FAIL full_done_count got=%0d want=%0d", done_log.size() - base, 6); end
    if (done_log.size() >= base + 6) begin
      for (int k = 0; k < 6; k++) begin
        total++; if (done_log[base+k] !== k + 1) begin bad++; $display("FAIL full_order[%0d] got=%0d want=%0d", k, done_log[base+k], k + 1); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int base;
    hold_forever = 1'b1;
    busy_hold = 2;
    push_job(10);
    wait_run(ok);
    cyc(); cyc();
    push_job(11);
    push_job(12);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL rst_pre_count got=%0d want=2", fifo_count); end
    base = done_log.size();
    done_ready = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", fifo_count); end
    total++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%0b want=1", seq_idle); end
    total++; if (job_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", job_ready); end
    total++; if (acc_in_base !== 12'h0) begin bad++; $display("FAIL rst_in_base got=%0h want=0", acc_in_base); end
    for (int i = 0; i < 10; i++) begin
      total++; if (acc_run !== 1'b0) begin bad++; $display("FAIL rst_run[%0d] got=%0b want=0", i, acc_run); end
      total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL rst_done[%0d] got=%0b want=0", i, done_valid); end
      cyc();
    end
    hold_forever = 1'b0;
    repeat (3) cyc();
    done_ready = 1'b0;
    total++; if (done_log.size() !== base) begin bad++; $display("FAIL rst_no_record got=%0d want=%0d", done_log.size(), base); end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    busy_hold = 0;
    push_job(11);
    push_job(12);
    wait_run(ok);
    cyc();
    busy_hold = 3;
    wait_done(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_wait got=%0b want=1", ok); end
    total++; if (done_id !== 4'd11) begin bad++; $display("FAIL to_id got=%0d want=11", done_id); end
    total++; if (done_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%0b want=1", done_timeout); end
    total++; if (done_cycles !== 16'd8) begin bad++; $display("FAIL to_cycles got=%0d want=8", done_cycles); end
    handshake();
    wait_done(ok);
    total++; if (done_id !== 4'd12) begin bad++; $display("FAIL to_next_id got=%0d want=12", done_id); end
    total++; if (done_timeout !== 1'b0) begin bad++; $display("FAIL to_next_flag got=%0b want=0", done_timeout); end
    total++; if (done_cycles !== 16'd4) begin bad++; $display("FAIL to_next_cycles got=%0d want=4", done_cycles); end
    handshake();
  endtask
`else
  task automatic test_timeout();
    bit ok;
    busy_hold = 0;
    push_job(11);
    wait_run(ok);
    for (int i = 0; i < 30; i++) begin
      cyc();
      total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL nto_wait[%0d] got=%0b want=0", i, done_valid); end
    end
    kick = 1'b1;
    cyc();
    kick = 1'b0;
    wait_done(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL nto_done got=%0b want=1", ok); end
    total++; if (done_cycles !== 16'd32) begin bad++; $display("FAIL nto_cycles got=%0d want=32", done_cycles); end
    total++; if (done_timeout !== 1'b0) begin bad++; $display("FAIL nto_flag got=%0b want=0", done_timeout); end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_push_pop();
    test_queue_full();
    test_reset_mid_run();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
